imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the ID stage of the MIPS-Lite 5-stage pipeline. Each accepted instruction is decoded into an extended immediate using a per-opcode mode: sign-extend, zero-extend for logical immediates, or shifted branch offset. Results are held in a 2-entry buffer with valid/ready handshakes, so ID→EX stalls never drop or duplicate an immediate. A flush input supports branch squash, and an optional counter tracks illegal opcodes.

---
 rtl/imm_gen_pipe.sv | 168 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// ID-stage immediate generator: per-opcode extension into a 2-entry valid/ready buffer.
// Optional illegal-opcode statistics counter is built when IMMGEN_STATS_EN is defined.
module imm_gen_pipe #(
    parameter int DATA       = 32,
    parameter int IMMSIZE    = 16,
    parameter int BR_SHIFT   = 0,
    parameter bit LOGIC_ZEXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_imm,
    output logic [1:0]      out_kind,
    output logic            out_illegal,
    output logic [7:0]      ill_cnt
);

    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_SEXT   = 2'd1,
        KIND_ZEXT   = 2'd2,
        KIND_BRANCH = 2'd3
    } kind_e;

    logic [5:0]         opcode_s;
    logic [IMMSIZE-1:0] imm_field_s;
    logic [DATA-1:0]    sext_s;
    logic [DATA-1:0]    zext_s;
    logic [DATA-1:0]    br_s;
    logic [DATA-1:0]    dec_imm_s;
    kind_e              dec_kind_s;
    logic               dec_ill_s;
    logic               unused_bits_s;

    logic [DATA-1:0]    imm_q [2];
    kind_e              kind_q [2];
    logic               ill_q [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               push_s;
    logic               pop_s;

    assign opcode_s      = in_instr[31:26];
    assign imm_field_s   = in_instr[IMMSIZE-1:0];
    assign unused_bits_s = ^in_instr[25:IMMSIZE];
    assign sext_s        = {{(DATA-IMMSIZE){imm_field_s[IMMSIZE-1]}}, imm_field_s};
    assign zext_s        = {{(DATA-IMMSIZE){1'b0}}, imm_field_s};
    assign br_s          = sext_s << BR_SHIFT;

    // Opcode decode into the {imm, kind, illegal} tuple; undefined opcodes yield zero.
    always_comb begin
        dec_imm_s  = '0;
        dec_kind_s = KIND_NONE;
        dec_ill_s  = 1'b0;
        if (opcode_s > 6'b010001) begin
            dec_ill_s = 1'b1;
        end else begin
            case (opcode_s)
                6'b000001, 6'b000011, 6'b000101, 6'b001100, 6'b001101: begin
                    dec_imm_s  = sext_s;
                    dec_kind_s = KIND_SEXT;
                end
                6'b000111, 6'b001001, 6'b001011: begin
                    if (LOGIC_ZEXT) begin
                        dec_imm_s  = zext_s;
                        dec_kind_s = KIND_ZEXT;
                    end else begin
                        dec_imm_s  = sext_s;
                        dec_kind_s = KIND_SEXT;
                    end
                end
                6'b001110, 6'b001111: begin
                    dec_imm_s  = br_s;
                    dec_kind_s = KIND_BRANCH;
                end
                default: begin
                    dec_imm_s  = '0;
                    dec_kind_s = KIND_NONE;
                end
            endcase
        end
    end

    // in_ready depends only on registered occupancy, so a pop never frees a same-cycle slot.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push_s    = in_valid & in_ready & ~flush;
    assign pop_s     = out_valid & out_ready & ~flush;

    // Pointer and occupancy next-state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer storage and control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i]  <= '0;
                kind_q[i] <= KIND_NONE;
                ill_q[i]  <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_s) begin
                imm_q[wr_ptr_q]  <= dec_imm_s;
                kind_q[wr_ptr_q] <= dec_kind_s;
                ill_q[wr_ptr_q]  <= dec_ill_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_kind    = out_valid ? kind_q[rd_ptr_q] : KIND_NONE;
    assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;

`ifdef IMMGEN_STATS_EN
    logic [7:0] ill_cnt_q;

    // Saturating count of accepted illegal opcodes; survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_cnt_q <= 8'd0;
        end else if (push_s && dec_ill_s && (ill_cnt_q != 8'hFF)) begin
            ill_cnt_q <= ill_cnt_q + 8'd1;
        end
    end

    assign ill_cnt = ill_cnt_q;
`else
    assign ill_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: default build plus a LOGIC_ZEXT=0 / BR_SHIFT=2 variant.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;

    logic        in_ready_a, out_valid_a, out_illegal_a;
    logic [31:0] out_imm_a;
    logic [1:0]  out_kind_a;
    logic [7:0]  ill_cnt_a;

    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [31:0] out_imm_b;
    logic [1:0]  out_kind_b;
    logic [7:0]  ill_cnt_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] ill_sat_exp;

    always #5 clk = ~clk;

    imm_gen_pipe dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
        .out_kind(out_kind_a), .out_illegal(out_illegal_a), .ill_cnt(ill_cnt_a)
    );

    imm_gen_pipe #(.BR_SHIFT(2), .LOGIC_ZEXT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
        .out_kind(out_kind_b), .out_illegal(out_illegal_b), .ill_cnt(ill_cnt_b)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'd0, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef IMMGEN_STATS_EN
        ill_sat_exp = 8'd255;
`else
        ill_sat_exp = 8'd0;
`endif
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   {31'd0, out_valid_a},   32'd0);
        chk("rst_imm",     out_imm_a,              32'd0);
        chk("rst_kind",    {30'd0, out_kind_a},    32'd0);
        chk("rst_illegal", {31'd0, out_illegal_a}, 32'd0);
        chk("rst_illcnt",  {24'd0, ill_cnt_a},     32'd0);
        chk("rst_ready",   {31'd0, in_ready_a},    32'd1);
        rst = 1'b0;

        // Decode modes with continuous throughput
        in_valid = 1'b1; out_ready = 1'b1;
        in_instr = mk(6'b000001, 16'hFFF0);
        step;
        chk("addi_valid", {31'd0, out_valid_a},   32'd1);
        chk("addi_imm",   out_imm_a,              32'hFFFF_FFF0);
        chk("addi_kind",  {30'd0, out_kind_a},    32'd1);
        chk("addi_ill",   {31'd0, out_illegal_a}, 32'd0);
        in_instr = mk(6'b000111, 16'h8001);
        step;
        chk("ori_imm_z",  out_imm_a,           32'h0000_8001);
        chk("ori_kind_z", {30'd0, out_kind_a}, 32'd2);
        chk("ori_imm_s",  out_imm_b,           32'hFFFF_8001);
        chk("ori_kind_s", {30'd0, out_kind_b}, 32'd1);
        in_instr = mk(6'b001111, 16'hFFFF);
        step;
        chk("beq_imm_sh0",  out_imm_a,           32'hFFFF_FFFF);
        chk("beq_imm_sh2",  out_imm_b,           32'hFFFF_FFFC);
        chk("beq_kind",     {30'd0, out_kind_b}, 32'd3);
        in_instr = mk(6'b010001, 16'h1234);
        step;
        chk("halt_imm",   out_imm_a,              32'd0);
        chk("halt_kind",  {30'd0, out_kind_a},    32'd0);
        chk("halt_ill",   {31'd0, out_illegal_a}, 32'd0);
        chk("halt_valid", {31'd0, out_valid_a},   32'd1);
        in_instr = mk(6'b001001, 16'h00F0);
        step;
        chk("andi_imm", out_imm_b, 32'h0000_00F0);
        in_valid = 1'b0;
        step;
        chk("drain_valid", {31'd0, out_valid_a}, 32'd0);

        // Back-pressure ordering
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = mk(6'b000001, 16'd1);
        step;
        chk("bp1_ready", {31'd0, in_ready_a}, 32'd1);
        chk("bp1_imm",   out_imm_a,           32'd1);
        in_instr = mk(6'b000011, 16'd2);
        step;
        chk("bp2_ready", {31'd0, in_ready_a}, 32'd0);
        chk("bp2_imm",   out_imm_a,           32'd1);
        in_instr = mk(6'b000101, 16'd3);
        step;
        chk("bp3_ready", {31'd0, in_ready_a}, 32'd0);
        chk("bp3_hold",  out_imm_a,           32'd1);
        out_ready = 1'b1;
        step;
        chk("bp_out2",   out_imm_a,           32'd2);
        chk("bp4_ready", {31'd0, in_ready_a}, 32'd1);
        step;
        chk("bp_out3",   out_imm_a,           32'd3);
        chk("bp_valid3", {31'd0, out_valid_a}, 32'd1);
        in_valid = 1'b0;
        step;
        chk("bp_empty",  {31'd0, out_valid_a}, 32'd0);

        // Flush with full and partially filled buffer
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = mk(6'b000001, 16'd5);
        step;
        in_instr = mk(6'b000001, 16'd6);
        step;
        chk("fl_full",  {31'd0, in_ready_a}, 32'd0);
        chk("fl_head",  out_imm_a,           32'd5);
        flush = 1'b1; in_instr = mk(6'b000001, 16'd7);
        step;
        chk("fl_valid", {31'd0, out_valid_a}, 32'd0);
        chk("fl_ready", {31'd0, in_ready_a},  32'd1);
        flush = 1'b0; in_instr = mk(6'b000001, 16'd8);
        step;
        flush = 1'b1; in_instr = mk(6'b000001, 16'd9);
        step;
        chk("fl2_valid", {31'd0, out_valid_a}, 32'd0);
        flush = 1'b0; in_instr = mk(6'b000001, 16'd10);
        step;
        chk("fl3_valid", {31'd0, out_valid_a}, 32'd1);
        chk("fl3_imm",   out_imm_a,            32'd10);
        in_valid = 1'b0; out_ready = 1'b1;
        step;

        // Illegal opcodes and counter saturation
        in_valid = 1'b1; in_instr = mk(6'b111111, 16'h1234);
        for (int i = 0; i < 300; i++) begin
            step;
            chk("ill_flag", {31'd0, out_illegal_a}, 32'd1);
            chk("ill_imm",  out_imm_a,              32'd0);
        end
        chk("ill_kind", {30'd0, out_kind_a}, 32'd0);
        in_valid = 1'b0;
        step;
        chk("ill_cnt_sat", {24'd0, ill_cnt_a}, {24'd0, ill_sat_exp});
        flush = 1'b1;
        step;
        flush = 1'b0;
        chk("ill_cnt_flush", {24'd0, ill_cnt_b}, {24'd0, ill_sat_exp});

        // Asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = mk(6'b000001, 16'd11);
        step;
        in_instr = mk(6'b000001, 16'd12);
        step;
        in_valid = 1'b0;
        chk("ar_pre_valid", {31'd0, out_valid_a}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid",  {31'd0, out_valid_a}, 32'd0);
        chk("ar_ready",  {31'd0, in_ready_a},  32'd1);
        chk("ar_illcnt", {24'd0, ill_cnt_a},   32'd0);
        chk("ar_imm",    out_imm_a,            32'd0);
        in_valid = 1'b1; out_ready = 1'b1; in_instr = mk(6'b000001, 16'd13);
        @(posedge clk);
        #1 rst = 1'b0;
        step;
        chk("ar_first_valid", {31'd0, out_valid_a}, 32'd1);
        chk("ar_first_imm",   out_imm_a,            32'd13);
        in_valid = 1'b0;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
